// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state codes, counter sizing
// and a wide two's-complement negate used for magnitude/sign handling.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Widest operand the negate helper supports; callers truncate to their width.
  localparam int MAX_W = 128;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {P,Q} left, subtract D when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  // One spare bit above P so the shifted partial remainder never overflows.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] d_ext;
  logic             fits;

  assign shifted = {p, q[WIDTH-1]};
  assign d_ext   = {2'b00, d};
  assign fits    = (shifted >= d_ext);

  assign p_next = fits ? (WIDTH+1)'(shifted - d_ext) : (WIDTH+1)'(shifted);
  assign q_next = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned at run time, with
// valid/ready handshakes on the request and result sides.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic             neg_q;
  logic             neg_r;

  logic             sgn;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return WIDTH'(twos_neg(MAX_W'(x)));
  endfunction

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Most-negative maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  always_comb begin
    sgn          = is_signed & SIGNED_EN;
    dividend_mag = (sgn & dividend[WIDTH-1]) ? neg_w(dividend) : dividend;
    divisor_mag  = (sgn & divisor[WIDTH-1])  ? neg_w(divisor)  : divisor;
    q_fix        = neg_q ? neg_w(q_reg) : q_reg;
    r_fix        = neg_r ? neg_w(p_reg[WIDTH-1:0]) : p_reg[WIDTH-1:0];
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .q      (q_reg),
    .d      (d_reg),
    .p_next (p_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            neg_q <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn & dividend[WIDTH-1];
            p_reg <= '0;
            q_reg <= dividend_mag;
            d_reg <= divisor_mag;
            count <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          p_reg <= p_step;
          q_reg <= q_step;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= 1'b0;
          state       <= ST_DONE;
        end
        default: begin
          if (out_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model (truncating signed division, C-style remainder).
module tb_div_seq;

  logic clk;
  logic rst;

  logic        in_valid32, in_ready32, signed32, out_valid32, out_ready32, dz32;
  logic [31:0] dividend32, divisor32, quot32, rem32;

  logic        in_valid8, in_ready8, signed8, out_valid8, out_ready8, dz8;
  logic [7:0]  dividend8, divisor8, quot8, rem8;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .dividend(dividend32), .divisor(divisor32), .is_signed(signed32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .quotient(quot32), .remainder(rem32), .div_by_zero(dz32)
  );

  div_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8), .is_signed(signed8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quot8), .remainder(rem8), .div_by_zero(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended 64-bit values.
  function automatic void ref_div(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit s, output longint unsigned q, output longint unsigned r,
                                  output bit dz);
    longint unsigned mask;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    dz = (b == 0);
    if (dz) begin
      q = mask;
      r = a;
    end else if (s) begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      q = longint'(sa / sb) & mask;
      r = longint'(sa % sb) & mask;
    end else begin
      q = (a / b) & mask;
      r = (a % b) & mask;
    end
  endfunction

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    n = 0;
    while (!in_ready32 && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready32) check("ready32_timeout", 72'(in_ready32), 72'd1);
    dividend32 = a; divisor32 = b; signed32 = s; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
  endtask

  task automatic wait32(output int lat);
    lat = 1;
    while (!out_valid32 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume32();
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      output logic [31:0] q, output logic [31:0] r, output logic dz, output int lat);
    start32(a, b, s);
    wait32(lat);
    q = quot32; r = rem32; dz = dz32;
    $display("div32 s=%0d %h / %h -> q=%h r=%h dz=%0d lat=%0d", s, a, b, q, r, dz, lat);
    consume32();
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [7:0] q, output logic [7:0] r, output logic dz, output int lat);
    int n;
    n = 0;
    while (!in_ready8 && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready8) check("ready8_timeout", 72'(in_ready8), 72'd1);
    dividend8 = a; divisor8 = b; signed8 = s; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
    q = quot8; r = rem8; dz = dz8;
    $display("div8 s=%0d %h / %h -> q=%h r=%h dz=%0d lat=%0d", s, a, b, q, r, dz, lat);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    logic [31:0] q, r, a, b, sq, sr;
    logic [7:0]  q8, r8, a8, b8;
    logic        dz, s;
    int          lat;
    longint unsigned eq, er, prod;
    bit          ed, ok;

    rst = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b0; dividend32 = '0; divisor32 = '0; signed32 = 1'b0;
    in_valid8  = 1'b0; out_ready8  = 1'b0; dividend8  = '0; divisor8  = '0; signed8  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {in_ready32, out_valid32, dz32}, 72'b100);
    check("reset_results", {quot32, rem32}, 72'd0);
    rst = 1'b0;

    op32(32'd100, 32'd7, 1'b0, q, r, dz, lat);
    check("u100_7", {q, r, dz}, {32'd14, 32'd2, 1'b0});
    check("u100_7_latency", 72'(lat), 72'd34);

    op32(32'hFFFFFFF9, 32'd2, 1'b1, q, r, dz, lat);
    check("s_m7_2", {q, r, dz}, {32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});

    op32(32'd7, 32'hFFFFFFFE, 1'b1, q, r, dz, lat);
    check("s_7_m2", {q, r, dz}, {32'hFFFFFFFD, 32'd1, 1'b0});

    op32(32'h12345678, 32'd0, 1'b0, q, r, dz, lat);
    check("div_zero", {q, r, dz}, {32'hFFFFFFFF, 32'h12345678, 1'b1});
    check("div_zero_latency", 72'(lat), 72'd1);

    op32(32'h80000000, 32'hFFFFFFFF, 1'b1, q, r, dz, lat);
    check("s_overflow", {q, r, dz}, {32'h80000000, 32'd0, 1'b0});

    op32(32'h80000000, 32'hFFFFFFFF, 1'b0, q, r, dz, lat);
    check("u_overflow_ops", {q, r, dz}, {32'd0, 32'h80000000, 1'b0});

    // Backpressure: result must hold and a pending request must not be taken.
    start32(32'd1000, 32'd3, 1'b0);
    wait32(lat);
    sq = quot32; sr = rem32;
    check("bp_result", {sq, sr}, {32'd333, 32'd1});
    dividend32 = 32'd5; divisor32 = 32'd1; in_valid32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid32, in_ready32, quot32, rem32}, {1'b1, 1'b0, sq, sr});
    end
    in_valid32 = 1'b0;
    consume32();
    check("bp_release", {out_valid32, in_ready32}, 72'b01);
    $display("div32 backpressure 1000 / 3 held 10 cycles");

    // Asynchronous reset in the middle of the iteration.
    start32(32'd123456, 32'd789, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_calc", {out_valid32, in_ready32}, 72'b01);
    @(negedge clk);
    rst = 1'b0;
    $display("div32 reset asserted at calc step 5");
    op32(32'd9, 32'd3, 1'b0, q, r, dz, lat);
    check("after_reset_9_3", {q, r, dz}, {32'd3, 32'd0, 1'b0});

    op8(8'h80, 8'hFF, 1'b1, q8, r8, dz, lat);
    check("s8_overflow", {q8, r8, dz}, {8'h80, 8'h00, 1'b0});
    check("s8_latency", 72'(lat), 72'd10);

    for (int i = 0; i < 800; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      op32(a, b, s, q, r, dz, lat);
      ref_div(32, 64'(a), 64'(b), s, eq, er, ed);
      check("rand32_result", {q, r, dz}, {eq[31:0], er[31:0], ed});
      prod = (64'(q) * 64'(b) + 64'(r)) & 64'hFFFFFFFF;
      ok = (prod == 64'(a)) && (lat == (ed ? 1 : 34));
      check("rand32_invariant_latency", 72'(ok), 72'd1);
    end

    for (int i = 0; i < 2000; i++) begin
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b8 = 8'd0;
        1: b8 = 8'hFF;
        2: a8 = 8'h80;
        3: b8 = 8'($urandom_range(1, 7));
        default: ;
      endcase
      op8(a8, b8, s, q8, r8, dz, lat);
      ref_div(8, 64'(a8), 64'(b8), s, eq, er, ed);
      check("rand8_result", {q8, r8, dz}, {eq[7:0], er[7:0], ed});
      prod = (64'(q8) * 64'(b8) + 64'(r8)) & 64'hFF;
      ok = (prod == 64'(a8)) && (lat == (ed ? 1 : 10));
      check("rand8_invariant_latency", 72'(ok), 72'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
